mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_issue_ctrl_pkg.sv | 16 +
 rtl/mul_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_issue_ctrl_pkg.sv
// PARAMS_pkg: shared parameters and the multiply issue FSM state type.
//   MUL_STAGES    - multiplier latency, start pulse to write-back cycle
//   REG_ADDR_SIZE - register address width
//   mul_state_e   - IDLE / BUSY / WB states of mul_issue_ctrl
package PARAMS_pkg;

  localparam int MUL_STAGES    = 5;
  localparam int REG_ADDR_SIZE = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue control for a single in-flight multi-cycle multiply.
// Decides whether the presented instruction may issue, starts the multiplier,
// tracks the in-flight destination and signals the write-back cycle.
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   issue_valid_i                 instruction presented this cycle
//   issue_is_mul_i                presented instruction is a MUL
//   issue_writes_rd_i             presented instruction writes rd
//   issue_uses_rs1_i/_rs2_i       source operand read flags
//   issue_rd_i/_rs1_i/_rs2_i      register addresses
//   flush_i                       kill in-flight multiply, ignore current issue
//   stall_o                       presented instruction not accepted (comb)
//   mul_start_o                   one-cycle multiplier start pulse
//   mul_busy_o                    a multiply is in flight (BUSY or WB)
//   wb_valid_o                    multiplier result written back this cycle
//   wb_rd_o                       write-back destination (qualify with wb_valid_o)
//   dbg_state_o                   current FSM state, for observation only
//
// Handshake: an instruction is accepted in a cycle where issue_valid_i=1,
// stall_o=0 and flush_i=0; the producer holds it until then.
module mul_issue_ctrl
  import PARAMS_pkg::*;
#(
  parameter int MUL_STAGES    = PARAMS_pkg::MUL_STAGES,
  parameter int REG_ADDR_SIZE = PARAMS_pkg::REG_ADDR_SIZE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     issue_valid_i,
  input  logic                     issue_is_mul_i,
  input  logic                     issue_writes_rd_i,
  input  logic                     issue_uses_rs1_i,
  input  logic                     issue_uses_rs2_i,
  input  logic [REG_ADDR_SIZE-1:0] issue_rd_i,
  input  logic [REG_ADDR_SIZE-1:0] issue_rs1_i,
  input  logic [REG_ADDR_SIZE-1:0] issue_rs2_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic                     mul_start_o,
  output logic                     mul_busy_o,
  output logic                     wb_valid_o,
  output logic [REG_ADDR_SIZE-1:0] wb_rd_o,
  output logic [1:0]               dbg_state_o
);

  // Counter must hold MUL_STAGES-1; keep at least one bit for MUL_STAGES==1.
  localparam int CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a one-cycle multiplier the write-back directly follows the start.
  localparam mul_state_e LOAD_STATE = (MUL_STAGES > 1) ? ST_BUSY : ST_WB;

  mul_state_e               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [REG_ADDR_SIZE-1:0] r_rd;

  logic w_busy;
  logic w_wb;
  logic w_active;
  logic w_rd_nz;
  logic w_struct;
  logic w_raw;
  logic w_waw;
  logic w_port;
  logic w_stall;
  logic w_mul_accept;

  assign w_busy   = (r_state == ST_BUSY);
  assign w_wb     = (r_state == ST_WB);
  assign w_active = (r_state != ST_IDLE);
  assign w_rd_nz  = (r_rd != '0);

  // Only one multiply can be in flight.
  assign w_struct = issue_is_mul_i & w_busy;

  // No forwarding: a reader of the pending destination waits until the
  // write-back cycle has completed.
  assign w_raw = w_active & w_rd_nz &
                 ((issue_uses_rs1_i & (issue_rs1_i == r_rd)) |
                  (issue_uses_rs2_i & (issue_rs2_i == r_rd)));

  assign w_waw = w_busy & issue_writes_rd_i & w_rd_nz & (issue_rd_i == r_rd);

  // A non-mul writer issued when cnt==1 would reach the register-file write
  // port in the same cycle as the multiply result.
  assign w_port = ~issue_is_mul_i & issue_writes_rd_i & w_busy & (r_cnt == CNT_ONE);

  assign w_stall = reset_n & issue_valid_i & ~flush_i &
                   (w_struct | w_raw | w_waw | w_port);

  assign w_mul_accept = reset_n & issue_valid_i & ~w_stall & ~flush_i & issue_is_mul_i;

  assign stall_o     = w_stall;
  assign mul_start_o = w_mul_accept;
  assign mul_busy_o  = reset_n & w_active;
  // A flush during WB does not retract this cycle's write-back.
  assign wb_valid_o  = reset_n & w_wb & w_rd_nz;
  assign wb_rd_o     = r_rd;
  assign dbg_state_o = r_state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mul_accept) begin
            r_state <= LOAD_STATE;
            r_cnt   <= CNT_LOAD;
            r_rd    <= issue_rd_i;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          // Back-to-back: a new multiply may start in the write-back cycle.
          if (w_mul_accept) begin
            r_state <= LOAD_STATE;
            r_cnt   <= CNT_LOAD;
            r_rd    <= issue_rd_i;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Testbench for mul_issue_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a timing-based model.
module tb_mul_issue_ctrl;
  import PARAMS_pkg::*;

  localparam int MS = 5;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          issue_valid_i, issue_is_mul_i, issue_writes_rd_i;
  logic          issue_uses_rs1_i, issue_uses_rs2_i;
  logic [AW-1:0] issue_rd_i, issue_rs1_i, issue_rs2_i;
  logic          flush_i;
  logic          stall_o, mul_start_o, mul_busy_o, wb_valid_o;
  logic [AW-1:0] wb_rd_o;
  logic [1:0]    dbg_state_o;

  mul_issue_ctrl #(.MUL_STAGES(MS), .REG_ADDR_SIZE(AW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .issue_valid_i     (issue_valid_i),
    .issue_is_mul_i    (issue_is_mul_i),
    .issue_writes_rd_i (issue_writes_rd_i),
    .issue_uses_rs1_i  (issue_uses_rs1_i),
    .issue_uses_rs2_i  (issue_uses_rs2_i),
    .issue_rd_i        (issue_rd_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_rs2_i       (issue_rs2_i),
    .flush_i           (flush_i),
    .stall_o           (stall_o),
    .mul_start_o       (mul_start_o),
    .mul_busy_o        (mul_busy_o),
    .wb_valid_o        (wb_valid_o),
    .wb_rd_o           (wb_rd_o),
    .dbg_state_o       (dbg_state_o)
  );

  // ---------------- vector record ----------------
  typedef struct {
    logic          rst_n, v, mul, wr, u1, u2;
    logic [AW-1:0] rd, rs1, rs2;
    logic          fl;
    logic          e_stall, e_start, e_wb, e_busy;
    logic [AW-1:0] e_rd;
    logic          rd_dc;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, v, mul, wr, u1, u2,
                              input int rd, rs1, rs2,
                              input logic fl, st, sa, wb, bu,
                              input int erd, input logic dc);
    vec_t t;
    t.rst_n = rst_n; t.v = v; t.mul = mul; t.wr = wr; t.u1 = u1; t.u2 = u2;
    t.rd = AW'(rd); t.rs1 = AW'(rs1); t.rs2 = AW'(rs2); t.fl = fl;
    t.e_stall = st; t.e_start = sa; t.e_wb = wb; t.e_busy = bu;
    t.e_rd = AW'(erd); t.rd_dc = dc;
    return t;
  endfunction

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the in-flight multiply by the absolute cycle of its write-back.
  bit            m_inflight = 1'b0;
  int            m_wb_at    = 0;
  logic [AW-1:0] m_rd       = '0;

  task automatic model_eval(input vec_t t, output logic st, sa, wb, bu);
    bit busy_s, wb_s, act, hz;
    busy_s = m_inflight && (cyc < m_wb_at);
    wb_s   = m_inflight && (cyc == m_wb_at);
    act    = busy_s || wb_s;
    hz = (t.mul && busy_s) ||
         (act && m_rd != 0 && ((t.u1 && t.rs1 == m_rd) || (t.u2 && t.rs2 == m_rd))) ||
         (busy_s && t.wr && m_rd != 0 && t.rd == m_rd) ||
         (!t.mul && t.wr && busy_s && (m_wb_at - cyc == 1));
    st = t.rst_n && t.v && !t.fl && hz;
    sa = t.rst_n && t.v && !t.fl && !hz && t.mul;
    wb = t.rst_n && wb_s && (m_rd != 0);
    bu = t.rst_n && act;
  endtask

  task automatic model_update(input vec_t t);
    logic st, sa, wb, bu;
    bit wb_s;
    model_eval(t, st, sa, wb, bu);
    wb_s = m_inflight && (cyc == m_wb_at);
    if (!t.rst_n) begin
      m_inflight = 1'b0;
      m_rd       = '0;
    end else if (t.fl) begin
      m_inflight = 1'b0;
    end else if (sa) begin
      m_inflight = 1'b1;
      m_wb_at    = cyc + MS;
      m_rd       = t.rd;
    end else if (wb_s) begin
      m_inflight = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drive, check at the falling edge,
  // advance the model at the next rising edge.
  task automatic run_vec(input vec_t t, input bit use_model);
    logic st, sa, wb, bu;
    reset_n           = t.rst_n;
    issue_valid_i     = t.v;
    issue_is_mul_i    = t.mul;
    issue_writes_rd_i = t.wr;
    issue_uses_rs1_i  = t.u1;
    issue_uses_rs2_i  = t.u2;
    issue_rd_i        = t.rd;
    issue_rs1_i       = t.rs1;
    issue_rs2_i       = t.rs2;
    flush_i           = t.fl;
    @(negedge clk);
    if (use_model) begin
      model_eval(t, st, sa, wb, bu);
      chk("rnd_stall", 32'(stall_o), 32'(st));
      chk("rnd_start", 32'(mul_start_o), 32'(sa));
      chk("rnd_wb_valid", 32'(wb_valid_o), 32'(wb));
      chk("rnd_busy", 32'(mul_busy_o), 32'(bu));
      chk("rnd_wb_rd", 32'(wb_rd_o), 32'(m_rd));
    end else begin
      chk("vec_stall", 32'(stall_o), 32'(t.e_stall));
      chk("vec_start", 32'(mul_start_o), 32'(t.e_start));
      chk("vec_wb_valid", 32'(wb_valid_o), 32'(t.e_wb));
      chk("vec_busy", 32'(mul_busy_o), 32'(t.e_busy));
      if (!t.rd_dc) chk("vec_wb_rd", 32'(wb_rd_o), 32'(t.e_rd));
    end
    @(posedge clk);
    model_update(t);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    run_vec(mk(0,0,0,0,0,0, 0,0,0, 0, 0,0,0,0, 0,1), 0);
  endtask

  task automatic idle(input int n, input logic wb, bu, input int erd);
    for (int i = 0; i < n; i++)
      run_vec(mk(1,0,0,0,0,0, 0,0,0, 0, 0,0,wb,bu, erd,0), 0);
  endtask

  vec_t tbl[$];

  initial begin
    reset_n = 1'b0; issue_valid_i = 1'b0; issue_is_mul_i = 1'b0;
    issue_writes_rd_i = 1'b0; issue_uses_rs1_i = 1'b0; issue_uses_rs2_i = 1'b0;
    issue_rd_i = '0; issue_rs1_i = '0; issue_rs2_i = '0; flush_i = 1'b0;
    @(posedge clk); #1;
    do_reset();
    do_reset();

    // ---- table: latency, RAW stall, independent issue, back-to-back, port ----
    tbl.push_back(mk(1,1,1,1,1,1, 5,1,2, 0, 0,1,0,0, 0,0)); // MUL x5 starts
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,1,0,1,1,1, 8,5,3, 0, 1,0,0,1, 5,0)); // ADD reads x5: RAW
    tbl.push_back(mk(1,1,0,1,1,1, 8,5,3, 0, 1,0,1,1, 5,0));   // WB cycle, still RAW
    tbl.push_back(mk(1,1,0,1,1,1, 8,5,3, 0, 0,0,0,0, 5,0));   // accepted
    tbl.push_back(mk(1,1,1,1,1,1, 5,1,2, 0, 0,1,0,0, 5,0));   // MUL x5
    tbl.push_back(mk(1,1,0,1,1,1, 8,6,7, 0, 0,0,0,1, 5,0));   // ADD reads x6: no stall
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0, 0, 0,0,0,1, 5,0));
    tbl.push_back(mk(1,1,1,1,1,1, 5,1,2, 0, 0,1,1,1, 5,0));   // MUL during WB
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0, 0, 0,0,0,1, 5,0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0, 0, 0,0,0,1, 5,0));
    tbl.push_back(mk(1,1,0,1,1,1, 7,1,2, 0, 0,0,0,1, 5,0));   // ADD x7, cnt==2: ok
    tbl.push_back(mk(1,1,0,1,1,1, 7,1,2, 0, 1,0,0,1, 5,0));   // ADD x7, cnt==1: port
    tbl.push_back(mk(1,1,0,1,1,1, 7,1,2, 0, 0,0,1,1, 5,0));   // accepted in WB
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0, 0, 0,0,0,0, 5,0));
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], 0);

    // ---- structural hazard: MUL while BUSY, accepted at WB ----
    do_reset();
    run_vec(mk(1,1,1,1,1,1, 5,1,2, 0, 0,1,0,0, 0,0), 0);
    idle(1, 0, 1, 5);
    for (int i = 0; i < 3; i++)
      run_vec(mk(1,1,1,1,1,1, 9,1,2, 0, 1,0,0,1, 5,0), 0);
    run_vec(mk(1,1,1,1,1,1, 9,1,2, 0, 0,1,1,1, 5,0), 0);
    idle(4, 0, 1, 9);
    idle(1, 1, 1, 9);
    idle(1, 0, 0, 9);

    // ---- flush while BUSY, MUL to x0 ----
    run_vec(mk(1,1,1,1,1,1, 5,1,2, 0, 0,1,0,0, 9,0), 0);
    idle(2, 0, 1, 5);
    run_vec(mk(1,0,0,0,0,0, 0,0,0, 1, 0,0,0,1, 5,0), 0);     // flush
    run_vec(mk(1,1,1,1,1,1, 6,1,2, 1, 0,0,0,0, 5,0), 0);     // flush ignores issue
    idle(1, 0, 0, 5);                                         // no WB for killed op
    run_vec(mk(1,1,1,1,1,1, 0,1,2, 0, 0,1,0,0, 5,0), 0);     // MUL x0
    run_vec(mk(1,1,0,1,1,1, 3,0,0, 0, 0,0,0,1, 0,0), 0);     // reads x0: no RAW
    idle(3, 0, 1, 0);
    idle(1, 0, 1, 0);                                         // WB of x0 suppressed
    idle(1, 0, 0, 0);

    // ---- flush during WB keeps this cycle's write-back ----
    run_vec(mk(1,1,1,1,1,1, 4,1,2, 0, 0,1,0,0, 0,0), 0);
    idle(4, 0, 1, 4);
    run_vec(mk(1,1,1,1,1,1, 6,1,2, 1, 0,0,1,1, 4,0), 0);
    idle(1, 0, 0, 4);

    // ---- reset mid-operation ----
    run_vec(mk(1,1,1,1,1,1, 5,1,2, 0, 0,1,0,0, 4,0), 0);
    idle(1, 0, 1, 5);
    run_vec(mk(0,1,0,1,1,1, 8,5,5, 0, 0,0,0,0, 5,0), 0);     // outputs quiet in reset
    run_vec(mk(1,1,1,1,1,1, 6,1,2, 0, 0,1,0,0, 0,0), 0);     // accepted immediately
    idle(4, 0, 1, 6);                                         // no WB of x5
    idle(1, 1, 1, 6);
    idle(1, 0, 0, 6);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      vec_t t;
      t = mk(($urandom_range(0, 59) != 0),
             ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 9) < 8),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             ($urandom_range(0, 24) == 0),
             0,0,0,0, 0,0);
      run_vec(t, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
